// File: rtl/pwm_pkg.sv
// Shared constants and FSM encoding for the PWM generator/capture pair.
package pwm_pkg;

    localparam int CNT_W      = 16;
    localparam int PWM_PERIOD = 16000;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_e;

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall pulse detection.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic enable,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!enable) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of each full PWM cycle on pwm_in; flags a stalled input.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 32000
) (
    input  logic             clk,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] timeon,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             timeout,
    output logic             level
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic rise, fall;

    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] timeon_q, timeon_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             stall;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .enable  (enable),
        .async_in(pwm_in),
        .level   (level),
        .rise    (rise),
        .fall    (fall)
    );

    // cnt parks at TIMEOUT in WAIT after a timeout; timeout_q keeps that from re-strobing.
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign stall   = (cnt_q == TIMEOUT_C) && !rise && !((state_q == WAIT) && timeout_q);

    always_comb begin
        state_d   = state_q;
        hi_cnt_d  = hi_cnt_q;
        timeon_d  = timeon_q;
        period_d  = period_q;
        timeout_d = timeout_q;
        valid_d   = 1'b0;

        if (rise) begin
            cnt_d = '0;
        end else if (cnt_q == TIMEOUT_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_inc;
        end

        if (stall) begin
            timeout_d = 1'b1;
            valid_d   = 1'b1;
            period_d  = '0;
            timeon_d  = level ? '1 : '0;
            state_d   = WAIT;
        end else begin
            case (state_q)
                WAIT: begin
                    if (rise) begin
                        state_d = HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        hi_cnt_d = cnt_inc;
                        state_d  = LOW;
                    end
                end
                LOW: begin
                    if (rise) begin
                        timeon_d  = hi_cnt_q;
                        period_d  = cnt_inc;
                        timeout_d = 1'b0;
                        valid_d   = 1'b1;
                        state_d   = HIGH;
                    end
                end
                default: state_d = WAIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!enable) begin
            state_q   <= WAIT;
            cnt_q     <= '0;
            hi_cnt_q  <= '0;
            timeon_q  <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            timeon_q  <= timeon_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeon  = timeon_q;
    assign period  = period_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: table-driven PWM vectors plus stall, edge and reset sequences.
module tb_pwm_capture;

    localparam int SYNC = 3;
    localparam int TMO  = 600;

    logic        clk    = 1'b0;
    logic        enable = 1'b0;
    logic        pwm_in = 1'b0;
    logic [15:0] timeon, period;
    logic        valid, timeout, level;

    always #5 clk = ~clk;

    pwm_capture #(
        .SYNC_STAGES(SYNC),
        .TIMEOUT    (TMO)
    ) dut (
        .clk    (clk),
        .enable (enable),
        .pwm_in (pwm_in),
        .timeon (timeon),
        .period (period),
        .valid  (valid),
        .timeout(timeout),
        .level  (level)
    );

    typedef struct {
        logic [15:0] on;
        logic [15:0] per;
        logic        to;
        int          lat_ref;
        int          lat_exp;
    } rec_t;

    typedef struct {
        int hi;
        int lo;
        int eon;
        int eper;
    } vec_t;

    rec_t        sb[$];
    vec_t        vecs[6];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          neg_cnt  = 0;
    int          last_rise = 0;
    bit          pending  = 1'b0;
    logic [15:0] pend_on  = '0;
    logic [15:0] pend_per = '0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Rising pin edge closes the previous period, so its expectation is queued here.
    task automatic rise_pin();
        pwm_in = 1'b1;
        if (pending) sb.push_back('{pend_on, pend_per, 1'b0, neg_cnt, SYNC + 2});
        last_rise = neg_cnt;
    endtask

    task automatic drive(input int hi, input int lo, input int eon, input int eper);
        rise_pin();
        pending  = 1'b1;
        pend_on  = 16'(eon);
        pend_per = 16'(eper);
        cycles(hi);
        pwm_in = 1'b0;
        cycles(lo);
    endtask

    task automatic stall_push(input int eon);
        sb.push_back('{16'(eon), 16'd0, 1'b1, last_rise, TMO + SYNC + 3});
        pending = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_timeon"},  int'(timeon),  0);
        check({tag, "_period"},  int'(period),  0);
        check({tag, "_valid"},   int'(valid),   0);
        check({tag, "_timeout"}, int'(timeout), 0);
        check({tag, "_level"},   int'(level),   0);
    endtask

    initial begin
        rec_t r;

        vecs[0] = '{100, 300, 100, 400};
        vecs[1] = '{1,   49,  1,   50};
        vecs[2] = '{10,  10,  10,  20};
        vecs[3] = '{49,  1,   49,  50};
        vecs[4] = '{3,   5,   3,   8};
        vecs[5] = '{250, 150, 250, 400};

        fork
            forever begin
                @(negedge clk);
                neg_cnt++;
                if (valid) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_valid: got strobe timeon=%0d period=%0d timeout=%0d expected none",
                                 timeon, period, timeout);
                    end else begin
                        r = sb.pop_front();
                        check("timeon",  int'(timeon),  int'(r.on));
                        check("period",  int'(period),  int'(r.per));
                        check("timeout", int'(timeout), int'(r.to));
                        check("latency", neg_cnt - r.lat_ref, r.lat_exp);
                    end
                end
            end
        join_none

        cycles(3);
        @(negedge clk);
        check_outputs_zero("reset");
        cycles(1);
        enable = 1'b1;

        foreach (vecs[i]) begin
            for (int p = 0; p < 3; p++) drive(vecs[i].hi, vecs[i].lo, vecs[i].eon, vecs[i].eper);
        end

        // stuck high after a good period
        rise_pin();
        stall_push(16'hFFFF);
        cycles(TMO + 50);
        check("stall_hi_timeout", int'(timeout), 1);
        check("stall_hi_level",   int'(level),   1);

        // resume: first period after timeout is not reported
        pwm_in = 1'b0;
        cycles(300);
        drive(100, 300, 100, 400);
        check("resume_timeout_held", int'(timeout), 1);
        drive(100, 300, 100, 400);
        drive(100, 300, 100, 400);
        check("resume_timeout_clr", int'(timeout), 0);

        // stuck low after a high phase
        rise_pin();
        stall_push(0);
        cycles(100);
        pwm_in = 1'b0;
        cycles(TMO + 50);
        check("stall_lo_timeout", int'(timeout), 1);
        check("stall_lo_level",   int'(level),   0);

        // period TMO+1: rise lands on cnt==TIMEOUT, edge wins
        drive(100, TMO + 1 - 100, 100, TMO + 1);
        drive(100, TMO + 1 - 100, 100, TMO + 1);
        drive(100, 300, 100, 400);
        // period TMO+2: timeout fires one cycle before the rise
        rise_pin();
        stall_push(0);
        cycles(100);
        pwm_in = 1'b0;
        cycles(TMO + 2 - 100);
        drive(100, 300, 100, 400);
        drive(100, 300, 100, 400);
        drive(100, 300, 100, 400);

        // reset while the FSM is in HIGH
        rise_pin();
        pending = 1'b0;
        cycles(100);
        pwm_in = 1'b0;
        enable = 1'b0;
        cycles(1);
        enable = 1'b1;
        @(negedge clk);
        check_outputs_zero("midreset");
        cycles(1);
        drive(100, 300, 100, 400);
        drive(100, 300, 100, 400);
        drive(100, 300, 100, 400);

        cycles(30);
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
